// File: rtl/cond_pkg.sv
// cond_pkg: condition codes, flag bit positions and flag type shared by the condition/flag unit.
package cond_pkg;
    typedef logic [3:0] flags_t;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;
endpackage

// File: rtl/cond_check.sv
// cond_check: combinational evaluation of a 4-bit condition field against stored NZCV flags.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] Cond,
    input  flags_t     Flags,
    output logic       CondEx
);
    logic n, z, c, v;
    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];
    always_comb begin
        CondEx = 1'b0;
        case (cond_e'(Cond))
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = n == v;
            COND_LT: CondEx = n != v;
            COND_GT: CondEx = ~z & (n == v);
            COND_LE: CondEx = z | (n != v);
            COND_AL: CondEx = 1'b1;
            COND_NV: CondEx = 1'b0;
        endcase
    end
endmodule

// File: rtl/cond_flag_unit.sv
// cond_flag_unit: NZCV flag register, condition check and write-strobe gating; COND_STATS_EN adds execute/squash counters.
module cond_flag_unit
    import cond_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    output logic       CondEx,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output flags_t     Flags
`ifdef COND_STATS_EN
    ,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] squash_cnt
`endif
);
    if (CNT_W < 8 || CNT_W > 32) begin : g_bad_cnt_w
        $error("CNT_W must be in 8..32");
    end
    logic go, commit;
    cond_check u_check (.Cond(Cond), .Flags(Flags), .CondEx(CondEx));
    assign go       = en & ~reset;
    assign commit   = go & CondEx;
    assign PCSrc    = PCS & commit;
    assign RegWrite = RegW & commit;
    assign MemWrite = MemW & commit;
    always_ff @(posedge clk) begin
        if (reset) begin
            Flags <= '0;
        end else if (commit) begin
            if (FlagW[1]) Flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
            if (FlagW[0]) Flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
        end
    end
`ifdef COND_STATS_EN
    // counters saturate rather than wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            exec_cnt   <= '0;
            squash_cnt <= '0;
        end else begin
            if (commit && exec_cnt != '1) exec_cnt <= exec_cnt + CNT_W'(1);
            if (go && !CondEx && squash_cnt != '1) squash_cnt <= squash_cnt + CNT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_cond_flag_unit.sv
// tb_cond_flag_unit: directed self-checking bench for cond_flag_unit; define COND_STATS_EN to cover the counters.
module tb_cond_flag_unit;
    logic       clk = 1'b0;
    logic       reset, en, PCS, RegW, MemW;
    logic [3:0] Cond, ALUFlags, Flags;
    logic [1:0] FlagW;
    logic       CondEx, PCSrc, RegWrite, MemWrite;
`ifdef COND_STATS_EN
    logic [7:0] exec_cnt, squash_cnt;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cond_flag_unit #(.CNT_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .Cond(Cond), .ALUFlags(ALUFlags),
        .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .CondEx(CondEx),
        .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .Flags(Flags)
`ifdef COND_STATS_EN
        , .exec_cnt(exec_cnt), .squash_cnt(squash_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setf(input logic [3:0] v);
        en = 1'b1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = v;
        tick();
        FlagW = 2'b00;
    endtask

    // ARM-style reference: base condition on Cond[3:1], inverted by Cond[0]
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, b;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cy;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cy & ~z;
            3'd5: b = n == v;
            3'd6: b = ~z & (n == v);
            default: b = 1'b1;
        endcase
        return b ^ c[0];
    endfunction

    initial begin
        reset = 1'b1; en = 1'b1; PCS = 1'b1; RegW = 1'b1; MemW = 1'b1;
        Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_flags", 32'(Flags), 0);
            check("rst_pcsrc", 32'(PCSrc), 0);
            check("rst_regwrite", 32'(RegWrite), 0);
            check("rst_memwrite", 32'(MemWrite), 0);
            check("rst_condex", 32'(CondEx), 1);
        end
        reset = 1'b0; FlagW = 2'b00;
        #1;
        check("release_regwrite", 32'(RegWrite), 1);
        check("release_pcsrc", 32'(PCSrc), 1);
        tick();
        PCS = 1'b0; MemW = 1'b0;
        setf(4'b0100);
        check("set_flags", 32'(Flags), 'b0100);
        Cond = 4'b0000; #1;
        check("eq_regwrite", 32'(RegWrite), 1);
        Cond = 4'b0001; #1;
        check("ne_regwrite", 32'(RegWrite), 0);
        check("ne_condex", 32'(CondEx), 0);
        setf(4'b1010);
        FlagW = 2'b01; ALUFlags = 4'b0101;
        tick();
        check("partial_cv", 32'(Flags), 'b1001);
        FlagW = 2'b10; ALUFlags = 4'b0110;
        tick();
        check("partial_nz", 32'(Flags), 'b0101);
        setf(4'b0000);
        Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b1111; MemW = 1'b1; #1;
        check("squash_memwrite", 32'(MemWrite), 0);
        tick();
        check("squash_flags", 32'(Flags), 0);
        en = 1'b0; Cond = 4'b1110; #1;
        check("idle_memwrite", 32'(MemWrite), 0);
        tick();
        check("idle_flags", 32'(Flags), 0);
        MemW = 1'b0;
        setf(4'b0100);
        reset = 1'b1; FlagW = 2'b11; ALUFlags = 4'b1111;
        tick();
        check("midrst_flags", 32'(Flags), 0);
        reset = 1'b0; FlagW = 2'b00; Cond = 4'b0000; #1;
        check("midrst_eq", 32'(RegWrite), 0);
        Cond = 4'b0001; #1;
        check("midrst_ne", 32'(RegWrite), 1);
        setf(4'b0100);
        Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b0000;
        tick();
        check("b2b_flags", 32'(Flags), 0);
        check("b2b_condex", 32'(CondEx), 0);
        setf(4'b1001); en = 1'b0; Cond = 4'b1010; #1;
        check("spot_ge", 32'(CondEx), 1);
        setf(4'b1000); en = 1'b0; Cond = 4'b1011; #1;
        check("spot_lt", 32'(CondEx), 1);
        setf(4'b0010); en = 1'b0; Cond = 4'b1000; #1;
        check("spot_hi", 32'(CondEx), 1);
        for (int f = 0; f < 16; f++) begin
            setf(4'(f));
            en = 1'b0;
            for (int c = 0; c < 16; c++) begin
                Cond = 4'(c); #1;
                check($sformatf("sweep_f%0h_c%0h", f, c), 32'(CondEx), 32'(ref_cond(4'(c), 4'(f))));
            end
        end
`ifdef COND_STATS_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("cnt_rst_exec", 32'(exec_cnt), 0);
        check("cnt_rst_squash", 32'(squash_cnt), 0);
        en = 1'b1; Cond = 4'b1110; FlagW = 2'b00;
        for (int i = 0; i < 300; i++) tick();
        check("exec_sat", 32'(exec_cnt), 255);
        check("squash_none", 32'(squash_cnt), 0);
        for (int i = 0; i < 5; i++) begin
            Cond = 4'b1111; tick();
            Cond = 4'b1110; tick();
        end
        check("squash_five", 32'(squash_cnt), 5);
        check("exec_still_sat", 32'(exec_cnt), 255);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("cnt_clr_exec", 32'(exec_cnt), 0);
        check("cnt_clr_squash", 32'(squash_cnt), 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cond_flag_unit.md
Name: cond_flag_unit

Overview:
- Sits directly downstream of the ALU in the single-cycle ARM datapath. Consumes ALUFlags {N,Z,C,V}.
- Holds the architectural NZCV flag register and evaluates the instruction's 4-bit condition field against the stored flags.
- Gates the decoder's raw PCS/RegW/MemW write strobes into the committed PCSrc/RegWrite/MemWrite used by the PC mux, register file and data memory.
- Updates the flags partially under FlagW control, and only when the instruction executes.

Parameters:
- CNT_W, default 32: width of the optional execute/squash statistics counters. Legal range 8..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  instruction valid/advance this cycle. 0 = bubble or stall.
- Cond  input  4  instruction condition field, Instr[31:28].
- ALUFlags  input  4  {N,Z,C,V} from the ALU for the current instruction.
- FlagW  input  2  flag write enables: [1] updates N,Z; [0] updates C,V.
- PCS  input  1  raw "writes PC" strobe from the decoder.
- RegW  input  1  raw register-write strobe.
- MemW  input  1  raw memory-write strobe.
- CondEx  output  1  condition passed: combinational from Cond and the registered Flags.
- PCSrc  output  1  PCS & CondEx & en & ~reset.
- RegWrite  output  1  RegW & CondEx & en & ~reset.
- MemWrite  output  1  MemW & CondEx & en & ~reset.
- Flags  output  4  registered {N,Z,C,V}.
- exec_cnt  output  CNT_W  executed instructions; present only with COND_STATS_EN.
- squash_cnt  output  CNT_W  squashed instructions; present only with COND_STATS_EN.

Behaviour:
- Reset:
  - Flags = 4'b0000 on the edge where reset = 1.
  - While reset = 1, PCSrc, RegWrite and MemWrite are forced to 0 regardless of the other inputs.
  - CondEx is not gated by reset and still reflects Flags.
- Condition evaluation:
  - Uses the registered Flags, i.e. the values before the current instruction's update. Never uses ALUFlags. No bypass.
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C & ~Z
  - 1001 LS: ~C | Z
  - 1010 GE: N == V
  - 1011 LT: N != V
  - 1100 GT: ~Z & (N == V)
  - 1101 LE: Z | (N != V)
  - 1110 AL: 1
  - 1111 NV: 0
- Flag update at the rising edge, when en & CondEx & ~reset:
  - FlagW[1] = 1: Flags[3:2] <= ALUFlags[3:2].
  - FlagW[0] = 1: Flags[1:0] <= ALUFlags[1:0].
  - FlagW = 00: no change.
  - Each half updates independently.
- Squashed or idle cycles (CondEx = 0 or en = 0):
  - Flags hold.
  - All gated strobes are 0.
- Latency:
  - Gated strobes are combinational, zero cycles.
  - A flag update is visible on Flags and CondEx in the cycle after the setting instruction.
- Simultaneous events:
  - reset = 1 with en = 1: reset wins; no flag update, no strobe.
  - Back-to-back instructions: instruction N+1 sees the flags written by instruction N.
- Reset mid-stream: Flags clear on that edge; the next instruction evaluates against 0000 (EQ fails, NE passes).

Optional Feature:
- Macro: COND_STATS_EN.
- When defined:
  - exec_cnt increments on each edge where en & CondEx & ~reset.
  - squash_cnt increments on each edge where en & ~CondEx & ~reset.
  - Both counters saturate at all-ones; no wrap.
  - Both clear to 0 on reset.
  - The two counters never increment in the same cycle.
- When undefined: no counter ports and no counter logic. All other behaviour is identical.

Decomposition:
- Package cond_pkg holds:
  - enum cond_e with the 16 encodings above.
  - localparams FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - typedef flags_t (logic [3:0]).
- One sub-module, cond_check: purely combinational (Cond, Flags) -> CondEx, containing the 16-way case. Instantiated once.
- Flag register, strobe gating and counters live in the top module.

Test Plan:
- Reset: reset=1 for 2 cycles with en=1, PCS=RegW=MemW=1, Cond=AL -> Flags=0000 and all gated strobes 0. Release reset -> RegWrite=1 in the same cycle.
- Flag set then EQ: en=1, Cond=AL, FlagW=11, ALUFlags=0100 -> next cycle Flags=0100. Then Cond=EQ, RegW=1 -> RegWrite=1. Then Cond=NE -> RegWrite=0, CondEx=0.
- Partial update: Flags=1010. Cond=AL, FlagW=01, ALUFlags=0101 -> Flags=1001. Then FlagW=10, ALUFlags=0110 -> Flags=0101.
- Squash holds flags: Flags=0000, Cond=EQ, FlagW=11, ALUFlags=1111, MemW=1 -> MemWrite=0 and Flags stay 0000. Repeat with en=0, Cond=AL -> Flags stay 0000.
- Signed compares: sweep all 16 Flags values × all 16 Cond codes -> CondEx matches the table. Spot checks: Flags=1001 with GE -> 1; Flags=1000 with LT -> 1; Flags=0010 with HI -> 1; Cond=1111 -> 0 for every Flags value.
- COND_STATS_EN, CNT_W=8:
  - Drive 300 executed instructions -> exec_cnt saturates at 255.
  - Interleave 5 squashed instructions -> squash_cnt=5.
  - Assert reset -> both counters return to 0.
